axis_stream_checker: RTL and testbench

- AXI4-Stream example slave/checker. Sits directly downstream of the switch's example master stream, on the switch MI side.
- Accepts the stream under programmable backpressure and checks every accepted beat against the master's deterministic pattern.
- Reports done, sticky error classes, an error count and the index of the first bad beat to the testbench/status logic.

---
 rtl/axis_stream_checker.sv | 157 +++++++++++++++
 tb/tb_axis_stream_checker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
// AXI4-Stream example slave: accepts the example master's stream under optional
// pseudo-random backpressure and checks each accepted beat against the
// deterministic pattern. It reports done, sticky error classes, an error count,
// the first bad beat index and the accepted beat count.
module axis_stream_checker #(
  parameter int unsigned TDATA_WIDTH = 24,
  parameter int unsigned NUM_SINGLES = 256,
  parameter int unsigned PACKET_LEN  = 16,
  parameter int unsigned NUM_PACKETS = 16,
  parameter int unsigned READY_MODE  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic                     done,
  output logic                     error,
  output logic [4:0]               err_flags,
  output logic [15:0]              err_count,
  output logic [15:0]              first_err_beat,
  output logic [15:0]              beat_count
);

  localparam int unsigned KeepW      = TDATA_WIDTH / 8;
  localparam int unsigned TotalBeats = NUM_SINGLES + NUM_PACKETS * PACKET_LEN;

  typedef enum logic [1:0] {StSingles, StPackets, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [15:0]       r_lfsr, w_lfsr_next;
  logic              r_tready;
  logic [15:0]       r_beat_count;
  logic [15:0]       r_pkt_idx;
  logic [4:0]        r_err_flags;
  logic [15:0]       r_err_count;
  logic [15:0]       r_first_err_beat;

  logic                   w_accept;
  logic [TDATA_WIDTH-1:0] w_exp_data;
  logic                   w_exp_last;
  logic                   w_single_end;
  logic                   w_final_beat;
  logic [4:0]             w_err_class;
  logic                   w_beat_err;

  assign w_accept     = s_axis_tvalid && r_tready;
  assign w_exp_data   = {KeepW{r_beat_count[7:0]}};
  // Expected framing comes from the beat position only, so a bad tlast cannot
  // desynchronise the checks on later beats.
  assign w_exp_last   = (r_state == StSingles) || (r_pkt_idx == 16'(PACKET_LEN - 1));
  assign w_single_end = (32'(r_beat_count) == NUM_SINGLES - 1);
  assign w_final_beat = (32'(r_beat_count) == TotalBeats - 1);
  // Fibonacci LFSR, taps 16,14,13,11.
  assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Next phase: advance on the accept of the last beat of each phase.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      unique case (r_state)
        StSingles: begin
          if (w_single_end) begin
            w_state_next = (NUM_PACKETS == 0) ? StDone : StPackets;
          end
        end
        StPackets: begin
          if (w_final_beat) begin
            w_state_next = StDone;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Per-beat error classes; beats past the expected stream are only overruns.
  always_comb begin
    w_err_class = 5'b00000;
    if (w_accept) begin
      if (r_state == StDone) begin
        w_err_class[4] = 1'b1;
      end else begin
        w_err_class[0] = (s_axis_tdata != w_exp_data);
        w_err_class[1] = (s_axis_tuser != ~r_beat_count[0]);
        w_err_class[2] = (s_axis_tlast != w_exp_last);
        w_err_class[3] = (s_axis_tkeep != {KeepW{1'b1}});
      end
    end
    w_beat_err = |w_err_class;
  end

  // Phase register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= StSingles;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Backpressure generator; tready is registered and independent of tvalid.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_lfsr   <= LFSR_SEED;
      r_tready <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_tready <= (READY_MODE == 0) ? 1'b1 : (w_lfsr_next[1:0] != 2'b00);
    end
  end

  // Beat counter and position within the current packet.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_beat_count <= 16'h0000;
      r_pkt_idx    <= 16'h0000;
    end else if (w_accept) begin
      if (r_beat_count != 16'hFFFF) begin
        r_beat_count <= r_beat_count + 16'h0001;
      end
      if (r_state == StPackets) begin
        r_pkt_idx <= (r_pkt_idx == 16'(PACKET_LEN - 1)) ? 16'h0000 : r_pkt_idx + 16'h0001;
      end
    end
  end

  // Sticky error capture.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_err_flags      <= 5'b00000;
      r_err_count      <= 16'h0000;
      r_first_err_beat <= 16'h0000;
    end else if (w_beat_err) begin
      r_err_flags <= r_err_flags | w_err_class;
      if (r_err_count != 16'hFFFF) begin
        r_err_count <= r_err_count + 16'h0001;
      end
      if (r_err_flags == 5'b00000) begin
        r_first_err_beat <= r_beat_count;
      end
    end
  end

  assign s_axis_tready  = r_tready;
  assign done           = (r_state == StDone);
  assign err_flags      = r_err_flags;
  assign error          = |r_err_flags;
  assign err_count      = r_err_count;
  assign first_err_beat = r_first_err_beat;
  assign beat_count     = r_beat_count;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker: two instances (constant and LFSR tready) share
// one stimulus bus; sel picks which one sees tvalid and which one is checked.
// A reference model pushes expected status per accepted beat and a monitor
// pops and compares after each accept.
module tb_axis_stream_checker;

  localparam int NS    = 256;
  localparam int PL    = 16;
  localparam int NP    = 16;
  localparam int TOTAL = NS + NP * PL;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        sel = 1'b0;
  logic        tvalid = 1'b0;
  logic [23:0] tdata = '0;
  logic [2:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;

  logic        rdy0, done0, err0, rdy1, done1, err1;
  logic [4:0]  flg0, flg1;
  logic [15:0] ecnt0, ferr0, bcnt0, ecnt1, ferr1, bcnt1;

  logic        m_rdy, m_done, m_err;
  logic [4:0]  m_flg;
  logic [15:0] m_ecnt, m_ferr, m_bcnt;

  always #5 aclk = ~aclk;

  axis_stream_checker #(.READY_MODE(0)) dut0 (
    .aclk(aclk), .areset(areset), .s_axis_tvalid(tvalid & ~sel), .s_axis_tready(rdy0),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .done(done0), .error(err0), .err_flags(flg0), .err_count(ecnt0),
    .first_err_beat(ferr0), .beat_count(bcnt0)
  );

  axis_stream_checker #(.READY_MODE(1)) dut1 (
    .aclk(aclk), .areset(areset), .s_axis_tvalid(tvalid & sel), .s_axis_tready(rdy1),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .done(done1), .error(err1), .err_flags(flg1), .err_count(ecnt1),
    .first_err_beat(ferr1), .beat_count(bcnt1)
  );

  always_comb begin
    m_rdy  = sel ? rdy1  : rdy0;
    m_done = sel ? done1 : done0;
    m_err  = sel ? err1  : err0;
    m_flg  = sel ? flg1  : flg0;
    m_ecnt = sel ? ecnt1 : ecnt0;
    m_ferr = sel ? ferr1 : ferr0;
    m_bcnt = sel ? bcnt1 : bcnt0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  // Reference model state
  typedef struct {
    int         beats;
    logic [4:0] flags;
    int         cnt;
    int         first;
    logic       done;
  } exp_t;

  exp_t       sb_q[$];
  int         m_beats;
  logic [4:0] m_flags;
  int         m_cnt;
  int         m_first;

  function automatic logic [4:0] ref_classes(input int n, input logic [23:0] d,
                                             input logic [2:0] k, input logic l,
                                             input logic u);
    logic [4:0] c;
    logic [7:0] b;
    logic       explast;
    c = 5'b00000;
    if (n >= TOTAL) return 5'b10000;
    b = n[7:0];
    for (int i = 0; i < 3; i++) if (d[8*i +: 8] != b) c[0] = 1'b1;
    c[1] = (u == n[0]);
    explast = (n < NS) ? 1'b1 : (((n - NS) % PL) == PL - 1);
    c[2] = (l != explast);
    c[3] = (k != 3'b111);
    return c;
  endfunction

  task automatic model_reset();
    m_beats = 0;
    m_flags = '0;
    m_cnt   = 0;
    m_first = 0;
    sb_q.delete();
  endtask

  task automatic model_beat();
    logic [4:0] c;
    exp_t       e;
    c = ref_classes(m_beats, tdata, tkeep, tlast, tuser);
    if (c != 0) begin
      if (m_flags == 0) m_first = m_beats;
      m_cnt++;
    end
    m_flags = m_flags | c;
    m_beats++;
    e.beats = m_beats;
    e.flags = m_flags;
    e.cnt   = m_cnt;
    e.first = m_first;
    e.done  = (m_beats >= TOTAL);
    sb_q.push_back(e);
  endtask

  // Monitor: compare status on the negedge following each accepting edge.
  initial begin
    logic pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge aclk);
      if (pending) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("beat_count", m_bcnt, e.beats);
          chk("err_flags", m_flg, e.flags);
          chk("err_count", m_ecnt, e.cnt);
          chk("first_err_beat", m_ferr, e.first);
          chk("done", m_done, e.done);
          chk("error", m_err, |e.flags);
        end
      end
      pending = tvalid && m_rdy && !areset;
    end
  end

  // All drivers start and end at posedge+2.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic send_beat(output bit ok);
    ok = 1'b0;
    tvalid = 1'b1;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge aclk);
      if (m_rdy) begin
        model_beat();
        ok = 1'b1;
      end
      @(posedge aclk);
      #2;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // kind: 0 golden, 1 data, 2 drop tlast, 3 user+keep, 4 random faults
  task automatic drive_fields(input int n, input int fbeat, input int kind);
    logic [7:0] b;
    int         r;
    b = n[7:0];
    tdata = {b, b, b};
    tkeep = 3'b111;
    tuser = ~n[0];
    tlast = (n < NS) ? 1'b1 : (((n - NS) % PL) == PL - 1);
    if (n == fbeat) begin
      if (kind == 1) tdata[15:8] = 8'h00;
      if (kind == 2) tlast = 1'b0;
      if (kind == 3) begin
        tuser = ~tuser;
        tkeep = 3'b011;
      end
    end
    if (kind == 4 && $urandom_range(0, 39) == 0) begin
      r = $urandom_range(0, 3);
      if (r == 0) tdata[$urandom_range(0, 23)] ^= 1'b1;
      if (r == 1) tuser = ~tuser;
      if (r == 2) tlast = ~tlast;
      if (r == 3) tkeep = 3'($urandom_range(0, 6));
    end
  endtask

  task automatic send_stream(input int first_n, input int nbeats, input int fbeat,
                             input int kind, input bit gaps);
    bit ok;
    for (int n = first_n; n < first_n + nbeats; n++) begin
      drive_fields(n, fbeat, kind);
      send_beat(ok);
      if (!ok) break;
      if (gaps && $urandom_range(0, 3) == 0) begin
        tvalid = 1'b0;
        idle($urandom_range(1, 3));
      end
    end
    tvalid = 1'b0;
    idle(2);
  endtask

  task automatic do_reset(input int cycles);
    areset = 1'b1;
    repeat (cycles) begin
      @(posedge aclk);
      #2;
      chk("rst_tready", m_rdy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_error", m_err, 0);
      chk("rst_flags", m_flg, 0);
      chk("rst_err_count", m_ecnt, 0);
      chk("rst_first_err", m_ferr, 0);
      chk("rst_beat_count", m_bcnt, 0);
    end
    tvalid = 1'b0;
    areset = 1'b0;
    model_reset();
    @(posedge aclk);
    #2;
    if (!sel) chk("tready_after_reset", m_rdy, 1);
  endtask

  task automatic end_check(input logic d, input logic [4:0] f, input int c,
                           input int fb, input int bc);
    chk("end_done", m_done, d);
    chk("end_flags", m_flg, f);
    chk("end_error", m_err, |f);
    chk("end_err_count", m_ecnt, c);
    chk("end_first_err", m_ferr, fb);
    chk("end_beat_count", m_bcnt, bc);
    chk("end_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    int lows;
    model_reset();
    idle(1);

    // Golden stream with random bubbles, then one overrun beat
    sel = 1'b0;
    do_reset(2);
    send_stream(0, TOTAL, -1, 0, 1'b1);
    end_check(1'b1, 5'b00000, 0, 0, TOTAL);
    send_stream(TOTAL, 1, -1, 0, 1'b0);
    end_check(1'b1, 5'b10000, 1, TOTAL, TOTAL + 1);

    // LFSR backpressure with tvalid held high
    sel = 1'b1;
    do_reset(2);
    lows = 0;
    fork
      send_stream(0, TOTAL, -1, 0, 1'b0);
      begin
        repeat (64) begin
          @(negedge aclk);
          if (!m_rdy) lows++;
        end
      end
    join
    chk("tready_low_seen", (lows > 0), 1);
    end_check(1'b1, 5'b00000, 0, 0, TOTAL);

    // Single-class faults
    sel = 1'b0;
    do_reset(2);
    send_stream(0, TOTAL, 300, 1, 1'b1);
    end_check(1'b1, 5'b00001, 1, 300, TOTAL);
    do_reset(2);
    send_stream(0, TOTAL, 271, 2, 1'b0);
    end_check(1'b1, 5'b00100, 1, 271, TOTAL);
    do_reset(2);
    send_stream(0, TOTAL, 10, 3, 1'b1);
    end_check(1'b1, 5'b01010, 1, 10, TOTAL);

    // Reset mid-stream at beat 100 with tvalid still high, then a fresh stream
    do_reset(2);
    send_stream(0, 100, -1, 0, 1'b0);
    drive_fields(100, -1, 0);
    tvalid = 1'b1;
    do_reset(2);
    send_stream(0, TOTAL, -1, 0, 1'b1);
    end_check(1'b1, 5'b00000, 0, 0, TOTAL);

    // Random faults under LFSR backpressure
    sel = 1'b1;
    do_reset(2);
    send_stream(0, TOTAL, -1, 4, 1'b1);
    end_check(1'b1, m_flags, m_cnt, m_first, TOTAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
